// File: rtl/xor_bit_deserializer.sv
// Collects LSB-first result bits into WIDTH-bit words behind a valid/ready output.
// Define XOR_DESER_PARITY_EN to add a registered word_parity output.
module xor_bit_deserializer #(
  parameter int WIDTH = 8,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  input  logic             flush,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic [LENW-1:0]  word_len
`ifdef XOR_DESER_PARITY_EN
  ,
  output logic             word_parity
`endif
);

  localparam logic [LENW-1:0] FULL = LENW'(WIDTH);

  logic [WIDTH-1:0] sr, sr_next;
  logic [LENW-1:0]  cnt, cnt_next;
  logic             flush_pend;
  logic             accept, slot_free, flush_any;
  logic             full_next, empty_next, load_full, load_part;

  assign bit_ready  = !rst && (cnt != FULL);
  assign accept     = bit_valid && bit_ready;
  assign slot_free  = !word_valid || word_ready;
  assign flush_any  = flush_pend || flush;
  assign cnt_next   = cnt + {{(LENW-1){1'b0}}, accept};
  assign full_next  = (cnt_next == FULL);
  assign empty_next = (cnt_next == '0);
  assign load_full  = full_next && slot_free;
  assign load_part  = flush_any && !full_next && !empty_next && slot_free;

  // The incoming bit lands at position cnt; upper bits stay zero because sr clears on every load.
  always_comb begin
    sr_next = sr;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && (cnt == LENW'(i))) sr_next[i] = bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      word_valid <= 1'b0;
      word_out   <= '0;
      word_len   <= '0;
`ifdef XOR_DESER_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      sr  <= sr_next;
      cnt <= cnt_next;
      if (word_valid && word_ready) word_valid <= 1'b0;

      if (load_full || load_part) begin
        word_out   <= sr_next;
        word_len   <= load_full ? FULL : cnt_next;
        word_valid <= 1'b1;
        sr         <= '0;
        cnt        <= '0;
`ifdef XOR_DESER_PARITY_EN
        word_parity <= ^sr_next;
`endif
      end

      // A pending flush is resolved by any load, by an empty count, or by the word filling up.
      if (load_full || load_part || empty_next || full_next)
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_bit_deserializer.sv
// Directed bench for xor_bit_deserializer with WIDTH=4 and hand-computed expectations.
module tb_xor_bit_deserializer;

  localparam int WIDTH = 4;
  localparam int LENW  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_valid, bit_in, bit_ready, flush;
  logic             word_valid, word_ready;
  logic [WIDTH-1:0] word_out;
  logic [LENW-1:0]  word_len;
`ifdef XOR_DESER_PARITY_EN
  logic             word_parity;
`endif

  int checks = 0;
  int errors = 0;

  xor_bit_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .flush      (flush),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_len   (word_len)
`ifdef XOR_DESER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic bv, input logic b, input logic fl, input logic wr);
    bit_valid  = bv;
    bit_in     = b;
    flush      = fl;
    word_ready = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; flush = 1'b0; word_ready = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre got %b want 0", bit_ready); end
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", word_valid); end
    checks++;
    if (word_out !== 4'b0000) begin errors++; $display("FAIL reset_out got %b want 0000", word_out); end
    checks++;
    if (word_len !== 3'd0) begin errors++; $display("FAIL reset_len got %0d want 0", word_len); end
    checks++;
    if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %b want 0", bit_ready); end
`ifdef XOR_DESER_PARITY_EN
    checks++;
    if (word_parity !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", word_parity); end
`endif
    bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_post got %b want 1", bit_ready); end
  endtask

  task automatic test_basic_word;
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", word_valid); end
    cyc(1, 1, 0, 1);
    checks++;
    if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", word_valid); end
    checks++;
    if (word_out !== 4'b1101) begin errors++; $display("FAIL basic_out got %b want 1101", word_out); end
    checks++;
    if (word_len !== 3'd4) begin errors++; $display("FAIL basic_len got %0d want 4", word_len); end
`ifdef XOR_DESER_PARITY_EN
    checks++;
    if (word_parity !== 1'b1) begin errors++; $display("FAIL basic_parity got %b want 1", word_parity); end
`endif
    cyc(0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", word_valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] bits;
    bits = 8'b1110_0001;
    for (int i = 0; i < 8; i++) cyc(1, bits[i], 0, 0);
    checks++;
    if (word_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", word_valid); end
    checks++;
    if (word_out !== 4'b0001) begin errors++; $display("FAIL stall_out_held got %b want 0001", word_out); end
    checks++;
    if (bit_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", bit_ready); end
    cyc(1, 1, 0, 0);
    checks++;
    if (word_out !== 4'b0001) begin errors++; $display("FAIL stall_out_stable got %b want 0001", word_out); end
    cyc(0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 4'b1110) begin
      errors++; $display("FAIL stall_second got v=%b %b want v=1 1110", word_valid, word_out);
    end
    checks++;
    if (word_len !== 3'd4) begin errors++; $display("FAIL stall_second_len got %0d want 4", word_len); end
    checks++;
    if (bit_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_after got %b want 1", bit_ready); end
`ifdef XOR_DESER_PARITY_EN
    checks++;
    if (word_parity !== 1'b1) begin errors++; $display("FAIL stall_parity got %b want 1", word_parity); end
`endif
    cyc(0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", word_valid); end
  endtask

  task automatic test_flush;
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 4'b0011) begin
      errors++; $display("FAIL flush_out got v=%b %b want v=1 0011", word_valid, word_out);
    end
    checks++;
    if (word_len !== 3'd3) begin errors++; $display("FAIL flush_len got %0d want 3", word_len); end
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    checks++;
    if (word_out !== 4'b0001 || word_len !== 3'd4) begin
      errors++; $display("FAIL flush_next got %b len %0d want 0001 len 4", word_out, word_len);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_flush_edges;
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 1, 1);
    checks++;
    if (word_out !== 4'b0101 || word_len !== 3'd4) begin
      errors++; $display("FAIL flush_full got %b len %0d want 0101 len 4", word_out, word_len);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_full_single got %b want 0", word_valid); end
    cyc(0, 0, 1, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", word_valid); end
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_stale got %b want 0", word_valid); end
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    checks++;
    if (word_out !== 4'b1100 || word_len !== 3'd4) begin
      errors++; $display("FAIL flush_empty_next got %b len %0d want 1100 len 4", word_out, word_len);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_flush_pending;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (word_out !== 4'b1111 || word_valid !== 1'b1) begin
      errors++; $display("FAIL pend_hold got v=%b %b want v=1 1111", word_valid, word_out);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (word_out !== 4'b0001 || word_len !== 3'd2) begin
      errors++; $display("FAIL pend_partial got %b len %0d want 0001 len 2", word_out, word_len);
    end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_word;
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    checks++;
    if (word_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", word_valid); end
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 1);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 4'b1010 || word_len !== 3'd4) begin
      errors++; $display("FAIL midrst_word got v=%b %b len %0d want v=1 1010 len 4", word_valid, word_out, word_len);
    end
    cyc(0, 0, 0, 1);
  endtask

  initial begin
    test_reset;
    test_basic_word;
    test_backpressure;
    test_flush;
    test_flush_edges;
    test_flush_pending;
    test_reset_mid_word;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_bit_deserializer.md
Name: xor_bit_deserializer

Overview:
Downstream consumer of the single-bit xorArrow output stream. It collects one result bit per accepted cycle, LSB-first, into WIDTH-bit words and hands each word on through a valid/ready handshake. It applies backpressure to the bit source when the word path stalls, and a flush input emits a partial word.

Parameters:
WIDTH, 8, bits per output word; legal range 2..32.
LENW, $clog2(WIDTH+1), width of the word_len port; derived, do not override.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
bit_valid  input  1  bit_in is valid this cycle.
bit_in  input  1  result bit, normally driven by xorArrow output1.
bit_ready  output  1  block can accept a bit this cycle.
flush  input  1  single-cycle request to emit the partial word.
word_valid  output  1  word_out/word_len hold a word.
word_ready  input  1  consumer accepts the word this cycle.
word_out  output  WIDTH  assembled word; first bit in bit 0; unused upper bits are 0.
word_len  output  LENW  number of valid bits in word_out (1..WIDTH).

Behaviour:
- State: shift register sr[WIDTH-1:0], count cnt (0..WIDTH), output register {word_out, word_len, word_valid}, flag flush_pend.
- Reset (rst=1 at an edge): sr=0, cnt=0, flush_pend=0, word_valid=0, word_out=0, word_len=0.
- bit_ready = !rst && (cnt != WIDTH). It is combinational from registers only, never from word_ready.
- Bit accept: bit_valid && bit_ready writes bit_in to sr[cnt] and increments cnt.
- Output slot is free in a cycle if !word_valid || word_ready.
- Complete word: the accepted bit makes cnt reach WIDTH.
  - If the slot is free: word_out=sr (including the new bit), word_len=WIDTH and word_valid=1 at the same edge. sr and cnt clear.
  - Otherwise cnt stays at WIDTH and bit_ready=0. The transfer happens at the first edge where the slot is free.
- Latency: last bit accepted at edge N gives word_valid=1 in the cycle after edge N. Back-to-back words at one bit per cycle sustain full rate when word_ready=1.
- word_valid clears at an edge with word_ready=1 unless a new word loads at that edge. word_out and word_len stay stable while word_valid && !word_ready.
- Flush:
  - flush=1 sets flush_pend.
  - When flush_pend (or flush this cycle) is set, cnt (after any same-cycle bit) is between 1 and WIDTH-1, and the slot is free: load word_out=sr with zero padding, word_len=cnt, clear sr, cnt and flush_pend.
  - If cnt is 0 after any same-cycle bit, the flush is dropped and flush_pend clears.
  - A bit and a flush in the same cycle: the bit is included first.
  - A flush arriving when cnt reaches WIDTH becomes a normal full-word transfer, and flush_pend clears.
  - Bits keep being accepted while flush_pend waits. They join the pending partial word.
- Reset mid-word or mid-stall: all state is discarded. No partial word is emitted.
- word_len width: LENW = $clog2(WIDTH+1) bits.

Optional Feature:
Macro XOR_DESER_PARITY_EN.
- Defined: extra output port word_parity (output, 1 bit) = XOR of all WIDTH bits of word_out. It is registered together with word_out, is 0 at reset, and is stable under stall.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4. Hold rst=1 for 2 edges with bit_valid=1 -> word_valid=0, word_out=0, word_len=0, and bit_ready=0 while rst=1 and 1 after release.
2. word_ready=1; feed bits 1,0,1,1 on consecutive cycles -> word_valid=1 for exactly one cycle, the cycle after the 4th bit, with word_out=4'b1101 and word_len=4. With XOR_DESER_PARITY_EN, word_parity=1.
3. word_ready=0; feed 1,0,0,0,0,1,1,1 -> first word 4'b0001 held stable and bit_ready=0 after the 8th bit. Then raise word_ready -> 4'b0001, then 4'b1110 on the next cycle, and bit_ready=1 after the transfer.
4. Feed 1,1,0, then flush=1 -> word_out=4'b0011, word_len=3, and the next word starts at bit 0.
5. flush=1 in the same cycle as the 4th bit -> a single full word with word_len=4. flush=1 with cnt=0 -> no word; the next 4 bits give a normal word.
6. Feed 2 bits, pulse rst, then feed 0,1,0,1 -> word_out=4'b1010 and word_len=4, with no trace of the earlier bits.
